// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and constants for the multiplexed seven-segment
//            display counter: digit type, radix values and segment glyphs.
// Glyphs   : active-high, bit0 = segment a ... bit6 = segment g.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam int RADIX_DEC = 10;
    localparam int RADIX_HEX = 16;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational hex digit to seven-segment glyph decoder.
// Ports    : digit_i - 4-bit digit value (0..F)
//            seg_o   - active-high segment pattern, bit0 = a ... bit6 = g
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  digit_t     digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_mux_counter.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_counter
// Purpose  : N-digit up/down display counter (radix 10 or 16) with prescaled
//            count tick, synchronous load and a time-multiplexed scan driver
//            for a common-cathode multi-digit seven-segment display.
// Ports    : clk          - clock
//            rst_n        - synchronous active-low reset
//            en_i         - count enable (low freezes prescaler and count)
//            up_i         - 1 = increment, 0 = decrement
//            load_i       - synchronous load strobe (wins over a tick)
//            load_value_i - load value, digit i in bits [4i+3:4i]
//            count_o      - registered count, same digit packing
//            wrap_o       - one-cycle pulse on full-range wrap
//            segments_o   - registered active-high segments, bit0 = a
//            digit_sel_o  - registered one-hot digit enable
// Options  : SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits
//            (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_mux_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10000000,
    parameter int SCAN_DIV   = 10000,
    parameter int RADIX      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_value_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic [6:0]              segments_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o
);

    localparam int PRE_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int SCAN_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam digit_t            DIGIT_MAX = digit_t'(RADIX - 1);

    generate
        if (RADIX != RADIX_DEC && RADIX != RADIX_HEX) begin : g_bad_radix
            $error("seg7_mux_counter: RADIX must be 10 or 16");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg7_mux_counter: NUM_DIGITS must be 1..8");
        end
        if (TICK_DIV < 1 || SCAN_DIV < 1) begin : g_bad_div
            $error("seg7_mux_counter: TICK_DIV and SCAN_DIV must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] count_q,     count_d;
    logic [PRE_W-1:0]        pre_q,       pre_d;
    logic                    wrap_q,      wrap_d;
    logic [SCAN_W-1:0]       scan_q,      scan_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic [6:0]              segments_q,  segments_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic                    tick;
    logic                    chain_carry;
    logic [4*NUM_DIGITS-1:0] stepped;
    logic [4*NUM_DIGITS-1:0] loaded;
    digit_t                  cur_digit;
    digit_t                  sel_digit;
    logic [6:0]              dec_seg;
    logic                    lz_blank;

    // ------------------------------------------------------------------------
    // Tick prescaler, ripple digit chain and load
    // ------------------------------------------------------------------------
    always_comb begin
        tick = en_i && (pre_q == PRE_LAST);

        // Carry/borrow enters digit 0 and ripples while digits roll over;
        // surviving the last digit means the whole count wrapped.
        chain_carry = 1'b1;
        stepped     = count_q;
        cur_digit   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur_digit = count_q[4*i +: 4];
            if (chain_carry) begin
                if (up_i) begin
                    if (cur_digit == DIGIT_MAX) begin
                        stepped[4*i +: 4] = '0;
                    end else begin
                        stepped[4*i +: 4] = cur_digit + 4'd1;
                        chain_carry       = 1'b0;
                    end
                end else begin
                    if (cur_digit == '0) begin
                        stepped[4*i +: 4] = DIGIT_MAX;
                    end else begin
                        stepped[4*i +: 4] = cur_digit - 4'd1;
                        chain_carry       = 1'b0;
                    end
                end
            end
        end

        // Decimal mode clamps out-of-range loaded digits to 9.
        loaded = load_value_i;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (RADIX == RADIX_DEC && load_value_i[4*i +: 4] > 4'd9) begin
                loaded[4*i +: 4] = 4'd9;
            end
        end

        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = loaded;
            pre_d   = '0;
        end else if (tick) begin
            count_d = stepped;
            wrap_d  = chain_carry;
            pre_d   = '0;
        end else if (en_i) begin
            pre_d   = pre_q + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Scan counter and display register inputs
    // ------------------------------------------------------------------------
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        sel_digit   = '0;
        digit_sel_d = '0;
        lz_blank    = (idx_q != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_digit      = count_q[4*i +: 4];
                digit_sel_d[i] = 1'b1;
            end
            // Blank only if the selected digit and everything above it is 0.
            if (i >= int'(idx_q) && count_q[4*i +: 4] != '0) begin
                lz_blank = 1'b0;
            end
        end
    end

    seg7_decoder u_decoder (
        .digit_i (sel_digit),
        .seg_o   (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign segments_d = lz_blank ? SEG_BLANK : dec_seg;
`else
    logic unused_blank;
    assign unused_blank = lz_blank;
    assign segments_d   = dec_seg;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            pre_q       <= '0;
            wrap_q      <= 1'b0;
            scan_q      <= '0;
            idx_q       <= '0;
            segments_q  <= SEG_0;
            digit_sel_q <= NUM_DIGITS'(1);
        end else begin
            count_q     <= count_d;
            pre_q       <= pre_d;
            wrap_q      <= wrap_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            segments_q  <= segments_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign count_o     = count_q;
    assign wrap_o      = wrap_q;
    assign segments_o  = segments_q;
    assign digit_sel_o = digit_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_counter
// Purpose  : Self-checking bench for seg7_mux_counter. A hex (RADIX=16) and a
//            decimal (RADIX=10) instance share the same stimulus; both are
//            compared every cycle against a value-level reference model,
//            plus directed checks on the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_counter;

    localparam int NUM_DIGITS = 2;
    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;

    logic [7:0] count_hex, count_dec;
    logic       wrap_hex, wrap_dec;
    logic [6:0] seg_hex, seg_dec;
    logic [1:0] sel_hex, sel_dec;

    always #5 clk = ~clk;

    seg7_mux_counter #(
        .NUM_DIGITS (NUM_DIGITS), .TICK_DIV (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),   .RADIX    (16)
    ) u_dut_hex (
        .clk (clk), .rst_n (rst_n), .en_i (en), .up_i (up), .load_i (load),
        .load_value_i (load_value), .count_o (count_hex), .wrap_o (wrap_hex),
        .segments_o (seg_hex), .digit_sel_o (sel_hex)
    );

    seg7_mux_counter #(
        .NUM_DIGITS (NUM_DIGITS), .TICK_DIV (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),   .RADIX    (10)
    ) u_dut_dec (
        .clk (clk), .rst_n (rst_n), .en_i (en), .up_i (up), .load_i (load),
        .load_value_i (load_value), .count_o (count_dec), .wrap_o (wrap_dec),
        .segments_o (seg_dec), .digit_sel_o (sel_dec)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model (index 0 = hex, 1 = decimal) ----------
    int         m_val [2];
    bit         m_wrap[2];
    logic [6:0] m_seg [2];
    logic [1:0] m_sel;
    int         m_pre, m_scan, m_idx;
    bit         m_valid = 1'b0;

    function automatic int rdx(int k);
        return (k == 0) ? 16 : 10;
    endfunction

    function automatic int rpow(int k, int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * rdx(k);
        return p;
    endfunction

    function automatic int digit_of(int k, int v, int i);
        return (v / rpow(k, i)) % rdx(k);
    endfunction

    function automatic logic [7:0] pack(int k, int v);
        return {4'(digit_of(k, v, 1)), 4'(digit_of(k, v, 0))};
    endfunction

    function automatic int value_of_load(int k, logic [7:0] lv);
        int v = 0;
        int nib;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = int'(lv[4*i +: 4]);
            if (k == 1 && nib > 9) nib = 9;
            v = v + nib * rpow(k, i);
        end
        return v;
    endfunction

    function automatic logic [6:0] glyph(int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] shown(int k, int v, int idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Leading zero: the value is smaller than the weight of this digit.
        if (idx != 0 && v < rpow(k, idx)) return 7'h00;
`endif
        return glyph(digit_of(k, v, idx));
    endfunction

    task automatic model_step();
        int  modv;
        bit  tick;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_val[k] = 0; m_wrap[k] = 1'b0; m_seg[k] = 7'h3F;
            end
            m_sel = 2'b01; m_pre = 0; m_scan = 0; m_idx = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            tick  = en && (m_pre == TICK_DIV - 1);
            m_sel = 2'(1 << m_idx);
            for (int k = 0; k < 2; k++) begin
                m_seg[k]  = shown(k, m_val[k], m_idx);
                modv      = rpow(k, NUM_DIGITS);
                m_wrap[k] = 1'b0;
                if (load) begin
                    m_val[k] = value_of_load(k, load_value);
                end else if (tick) begin
                    if (up) begin
                        m_wrap[k] = (m_val[k] == modv - 1);
                        m_val[k]  = (m_val[k] + 1) % modv;
                    end else begin
                        m_wrap[k] = (m_val[k] == 0);
                        m_val[k]  = (m_val[k] + modv - 1) % modv;
                    end
                end
            end
            if (load || tick) m_pre = 0;
            else if (en)      m_pre = m_pre + 1;
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % NUM_DIGITS;
            end else begin
                m_scan = m_scan + 1;
            end
        end
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        if (m_valid) begin
            check("hex.count", 32'(count_hex), 32'(pack(0, m_val[0])));
            check("hex.wrap",  32'(wrap_hex),  32'(m_wrap[0]));
            check("hex.sel",   32'(sel_hex),   32'(m_sel));
            check("hex.seg",   32'(seg_hex),   32'(m_seg[0]));
            check("dec.count", 32'(count_dec), 32'(pack(1, m_val[1])));
            check("dec.wrap",  32'(wrap_dec),  32'(m_wrap[1]));
            check("dec.sel",   32'(sel_dec),   32'(m_sel));
            check("dec.seg",   32'(seg_dec),   32'(m_seg[1]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        logic [6:0] exp_seg;
        int         pick;

        // Reset
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
        cycle(); cycle();
        check("rst.count", 32'(count_hex), 32'h00);
        check("rst.sel",   32'(sel_hex),   32'h1);
        check("rst.seg",   32'(seg_hex),   32'h3F);
        check("rst.wrap",  32'(wrap_hex),  32'h0);

        // Scenario 1: free count up, then reset mid-run
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        repeat (4) cycle();
        check("s1.count4", 32'(count_hex), 32'h01);
        repeat (60) cycle();
        check("s1.count64.hex", 32'(count_hex), 32'h10);
        check("s1.count64.dec", 32'(count_dec), 32'h16);
        rst_n = 1'b0;
        cycle();
        check("s1.rst.count", 32'(count_hex), 32'h00);
        check("s1.rst.sel",   32'(sel_hex),   32'h1);
        check("s1.rst.seg",   32'(seg_hex),   32'h3F);
        rst_n = 1'b1;

        // Scenario 2: decimal wrap up and load saturation
        load = 1'b1; load_value = 8'h99;
        cycle();
        load = 1'b0;
        check("s2.load.dec", 32'(count_dec), 32'h99);
        repeat (3) cycle();
        check("s2.prewrap.dec", 32'(wrap_dec), 32'h0);
        cycle();
        check("s2.wrap.dec.count", 32'(count_dec), 32'h00);
        check("s2.wrap.dec",       32'(wrap_dec),  32'h1);
        check("s2.hex.count",      32'(count_hex), 32'h9A);
        check("s2.hex.nowrap",     32'(wrap_hex),  32'h0);
        cycle();
        check("s2.wrap.oneshot", 32'(wrap_dec), 32'h0);
        load = 1'b1; load_value = 8'hAF;
        cycle();
        load = 1'b0;
        check("s2.sat.dec", 32'(count_dec), 32'h99);
        check("s2.sat.hex", 32'(count_hex), 32'hAF);

        // Scenario 3: down wrap, enable freeze keeps prescaler phase
        load = 1'b1; load_value = 8'h00; up = 1'b0;
        cycle();
        load = 1'b0;
        repeat (4) cycle();
        check("s3.hex.ff",   32'(count_hex), 32'hFF);
        check("s3.hex.wrap", 32'(wrap_hex),  32'h1);
        check("s3.dec.99",   32'(count_dec), 32'h99);
        check("s3.dec.wrap", 32'(wrap_dec),  32'h1);
        repeat (2) cycle();
        en = 1'b0;
        repeat (10) cycle();
        check("s3.hold", 32'(count_hex), 32'hFF);
        en = 1'b1;
        cycle();
        check("s3.resume1", 32'(count_hex), 32'hFF);
        cycle();
        check("s3.resume2", 32'(count_hex), 32'hFE);

        // Scenario 4: load coincident with a tick
        up = 1'b1;
        for (int k = 0; k < TICK_DIV && m_pre != TICK_DIV - 1; k++) cycle();
        load = 1'b1; load_value = 8'h42;
        cycle();
        load = 1'b0;
        check("s4.load",   32'(count_hex), 32'h42);
        check("s4.nowrap", 32'(wrap_hex),  32'h0);
        repeat (3) cycle();
        check("s4.wait", 32'(count_hex), 32'h42);
        cycle();
        check("s4.tick", 32'(count_hex), 32'h43);

        // Scenario 5: scan alignment with count 3A
        en = 1'b0; load = 1'b1; load_value = 8'h3A;
        cycle();
        load = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            exp_seg = (m_sel == 2'b01) ? 7'h77 : 7'h4F;
            check("s5.seg", 32'(seg_hex), 32'(exp_seg));
        end

        // Scenario 6: leading zero behaviour with count 05
        load = 1'b1; load_value = 8'h05;
        cycle();
        load = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            exp_seg = (m_sel == 2'b01) ? 7'h6D : 7'h00;
`else
            exp_seg = (m_sel == 2'b01) ? 7'h6D : 7'h3F;
`endif
            check("s6.seg", 32'(seg_hex), 32'(exp_seg));
        end

        // Randomised run against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            en    = ($urandom_range(0, 3) != 0);
            up    = 1'($urandom_range(0, 1));
            load  = ($urandom_range(0, 31) == 0);
            pick  = int'($urandom_range(0, 3));
            case (pick)
                0:       load_value = 8'hFF;
                1:       load_value = 8'h99;
                2:       load_value = 8'h00;
                default: load_value = 8'($urandom);
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
